// File: rtl/ledpanel_pkg.sv
// Shared types and defaults for the LED panel scan controller.
package ledpanel_pkg;

  localparam int unsigned RGB_W    = 6;
  localparam int unsigned DEF_COLS = 32;
  localparam int unsigned DEF_ROWS = 16;
  localparam int unsigned TMR_W    = 16;
  localparam int unsigned DIV_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_CLK_HI  = 3'd3,
    ST_LATCH   = 3'd4,
    ST_DISPLAY = 3'd5,
    ST_NEXT    = 3'd6
  } scan_state_e;

endpackage

// File: rtl/ledpanel_timer.sv
// Loadable down-counter with a registered zero flag; shared by the
// panel-clock half-period and the display on-time delays.
module ledpanel_timer
  import ledpanel_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             zero
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  // Load wins over decrement; the counter parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      zero  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      zero  <= (cnt_d == '0);
    end
  end

endmodule

// File: rtl/ledpanel_scan_ctrl.sv
// HUB75-style LED panel scanner: shifts one row of pixels from the frame
// buffer, latches it, and lights it for a programmable on-time.
module ledpanel_scan_ctrl
  import ledpanel_pkg::*;
#(
  parameter int unsigned COLS = DEF_COLS,
  parameter int unsigned ROWS = DEF_ROWS
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic                           cfg_enable,
  input  logic [DIV_W-1:0]               cfg_clk_div,
  input  logic [TMR_W-1:0]               cfg_on_time,
  output logic [$clog2(ROWS)+$clog2(COLS)-1:0] rd_addr,
  input  logic [RGB_W-1:0]               rd_data,
  output logic [RGB_W-1:0]               rgb,
  output logic                           panel_clk,
  output logic                           lat,
  output logic                           oe_n,
  output logic [$clog2(ROWS)-1:0]        row_addr,
  output logic                           busy,
  output logic                           frame_done
);

  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned COL_W = $clog2(COLS);

  scan_state_e state_q, state_d;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [DIV_W-1:0] div_q;
  logic [TMR_W-1:0] on_q;
  logic             load_first_q;

  logic             cap_cfg;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero;

  logic             oe_n_d;
  logic             panel_clk_d;
  logic             lat_d;
  logic             busy_d;
  logic             frame_done_d;

  ledpanel_timer u_timer (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, counter updates, timer loads and next output values.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    cap_cfg      = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_enable) begin
          state_d = ST_ADDR;
          col_d   = '0;
          cap_cfg = 1'b1;
        end
      end
      ST_ADDR: begin
        state_d  = ST_LOAD;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(div_q);
      end
      ST_LOAD: begin
        if (tmr_zero) begin
          state_d  = ST_CLK_HI;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(div_q);
        end
      end
      ST_CLK_HI: begin
        if (tmr_zero) begin
          if (col_q == COL_W'(COLS - 1)) begin
            state_d = ST_LATCH;
          end else begin
            col_d   = col_q + COL_W'(1);
            state_d = ST_ADDR;
          end
        end
      end
      ST_LATCH: begin
        // A zero on-time skips DISPLAY so oe_n never drops.
        if (on_q == '0) begin
          state_d = ST_NEXT;
        end else begin
          state_d  = ST_DISPLAY;
          tmr_load = 1'b1;
          tmr_val  = on_q - TMR_W'(1);
        end
      end
      ST_DISPLAY: begin
        if (tmr_zero) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (row_q == ROW_W'(ROWS - 1)) begin
          row_d = '0;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
        if (cfg_enable) begin
          state_d = ST_ADDR;
          col_d   = '0;
          cap_cfg = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_NEXT && row_q == ROW_W'(ROWS - 1)) begin
      frame_done_d = 1'b1;
    end

    oe_n_d      = (state_d != ST_DISPLAY);
    panel_clk_d = (state_d == ST_CLK_HI);
    lat_d       = (state_d == ST_LATCH);
    busy_d      = (state_d != ST_IDLE);
  end

  // Datapath and registered panel outputs, aligned with the state they follow.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      col_q        <= '0;
      row_q        <= '0;
      div_q        <= '0;
      on_q         <= '0;
      load_first_q <= 1'b0;
      rd_addr      <= '0;
      rgb          <= '0;
      panel_clk    <= 1'b0;
      lat          <= 1'b0;
      oe_n         <= 1'b1;
      row_addr     <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      load_first_q <= (state_q == ST_ADDR);
      panel_clk    <= panel_clk_d;
      lat          <= lat_d;
      oe_n         <= oe_n_d;
      busy         <= busy_d;
      frame_done   <= frame_done_d;
      if (cap_cfg) begin
        div_q <= cfg_clk_div;
        on_q  <= cfg_on_time;
      end
      if (state_d == ST_ADDR) begin
        rd_addr <= {row_d, col_d};
      end
      // Read data is valid during the first LOAD cycle only.
      if (load_first_q) begin
        rgb <= rd_data;
      end
      if (state_d == ST_LATCH) begin
        row_addr <= row_q;
      end
    end
  end

endmodule

// File: tb/tb_ledpanel_scan_ctrl.sv
// Directed bench for ledpanel_scan_ctrl with a one-cycle-latency frame buffer model.
`timescale 1ns/1ps
module tb_ledpanel_scan_ctrl;

  logic        tb_ACLK;
  logic        tb_ARESETN;
  logic        cfg_enable;
  logic [7:0]  cfg_clk_div;
  logic [15:0] cfg_on_time;
  logic [8:0]  rd_addr;
  logic [5:0]  rd_data;
  logic [5:0]  rgb;
  logic        panel_clk;
  logic        lat;
  logic        oe_n;
  logic [3:0]  row_addr;
  logic        busy;
  logic        frame_done;

  int total;
  int bad;

  logic [8:0] hot_addr;

  // Results of the most recent run_rows call.
  int         busy_cycles;
  int         rises;
  int         lats;
  int         oe_low;
  int         fd_cnt;
  int         fd_at;
  logic       fd_oe;
  logic [8:0] drop_addr;
  logic       timed_out;
  logic [5:0] rise_rgb [0:63];
  logic [3:0] lat_row  [0:31];

  ledpanel_scan_ctrl dut (
    .ACLK        (tb_ACLK),
    .ARESETN     (tb_ARESETN),
    .cfg_enable  (cfg_enable),
    .cfg_clk_div (cfg_clk_div),
    .cfg_on_time (cfg_on_time),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rgb         (rgb),
    .panel_clk   (panel_clk),
    .lat         (lat),
    .oe_n        (oe_n),
    .row_addr    (row_addr),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  initial tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  always @(posedge tb_ACLK) begin
    rd_data <= (rd_addr == hot_addr) ? 6'b101010 : 6'b000000;
  end

  task automatic apply_reset();
    cfg_enable = 1'b0;
    @(negedge tb_ACLK);
    tb_ARESETN = 1'b0;
    @(negedge tb_ACLK);
    @(negedge tb_ACLK);
    tb_ARESETN = 1'b1;
  endtask

  // Enable scanning, drop enable at busy cycle drop_cycle, run until idle.
  task automatic run_rows(input int drop_cycle);
    logic prev_pclk;
    logic started;
    logic done;
    busy_cycles = 0; rises = 0; lats = 0; oe_low = 0;
    fd_cnt = 0; fd_at = -1; fd_oe = 1'b0; drop_addr = '0;
    prev_pclk = 1'b0; started = 1'b0; done = 1'b0;
    cfg_enable = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge tb_ACLK);
      if (busy) begin
        started = 1'b1;
        busy_cycles++;
        if (busy_cycles == drop_cycle) begin
          drop_addr  = rd_addr;
          cfg_enable = 1'b0;
        end
      end else if (started) begin
        done = 1'b1;
        break;
      end
      if (panel_clk && !prev_pclk) begin
        if (rises < 64) rise_rgb[rises] = rgb;
        rises++;
      end
      prev_pclk = panel_clk;
      if (lat) begin
        if (lats < 32) lat_row[lats] = row_addr;
        lats++;
      end
      if (!oe_n) oe_low++;
      if (frame_done) begin
        fd_cnt++;
        fd_at = busy_cycles;
        fd_oe = oe_n;
      end
    end
    cfg_enable = 1'b0;
    timed_out = !done;
  endtask

  task automatic test_reset();
    tb_ARESETN = 1'b1;
    #2 tb_ARESETN = 1'b0;
    @(negedge tb_ACLK);
    @(negedge tb_ACLK);
    total++; if (oe_n !== 1'b1) begin bad++; $display("FAIL reset_oe_n: got %b want 1", oe_n); end
    total++; if (panel_clk !== 1'b0) begin bad++; $display("FAIL reset_panel_clk: got %b want 0", panel_clk); end
    total++; if (lat !== 1'b0) begin bad++; $display("FAIL reset_lat: got %b want 0", lat); end
    total++; if (rgb !== 6'd0) begin bad++; $display("FAIL reset_rgb: got %b want 0", rgb); end
    total++; if (row_addr !== 4'd0) begin bad++; $display("FAIL reset_row_addr: got %0d want 0", row_addr); end
    total++; if (rd_addr !== 9'd0) begin bad++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    tb_ARESETN = 1'b1;
  endtask

  task automatic test_single_row();
    logic [5:0] exp_rgb;
    hot_addr    = 9'd5;
    cfg_clk_div = 8'd0;
    cfg_on_time = 16'd10;
    @(negedge tb_ACLK);
    run_rows(1);
    total++; if (timed_out) begin bad++; $display("FAIL row_timeout: got timeout want idle"); end
    total++; if (busy_cycles != 108) begin bad++; $display("FAIL row_duration: got %0d want 108", busy_cycles); end
    total++; if (rises != 32) begin bad++; $display("FAIL row_clk_rises: got %0d want 32", rises); end
    total++; if (lats != 1) begin bad++; $display("FAIL row_lat_pulses: got %0d want 1", lats); end
    total++; if (oe_low != 10) begin bad++; $display("FAIL row_oe_low: got %0d want 10", oe_low); end
    total++; if (lat_row[0] !== 4'd0) begin bad++; $display("FAIL row_addr0: got %0d want 0", lat_row[0]); end
    total++; if (fd_cnt != 0) begin bad++; $display("FAIL row_no_frame_done: got %0d want 0", fd_cnt); end
    for (int i = 0; i < 32; i++) begin
      exp_rgb = (i == 5) ? 6'b101010 : 6'b000000;
      total++;
      if (rise_rgb[i] !== exp_rgb) begin
        bad++; $display("FAIL data_align rise %0d: got %b want %b", i + 1, rise_rgb[i], exp_rgb);
      end
    end
  endtask

  task automatic test_async_reset();
    logic seen;
    seen = 1'b0;
    cfg_clk_div = 8'd0;
    cfg_on_time = 16'd10;
    cfg_enable  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge tb_ACLK);
      if (!oe_n) begin seen = 1'b1; break; end
    end
    total++; if (!seen) begin bad++; $display("FAIL areset_reach_display: got no oe_n low want oe_n low"); end
    @(negedge tb_ACLK);
    @(negedge tb_ACLK);
    @(negedge tb_ACLK);
    #2 tb_ARESETN = 1'b0;
    #1;
    total++; if (oe_n !== 1'b1) begin bad++; $display("FAIL areset_oe_n: got %b want 1", oe_n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL areset_busy: got %b want 0", busy); end
    cfg_enable = 1'b0;
    @(negedge tb_ACLK);
    tb_ARESETN = 1'b1;
    @(negedge tb_ACLK);
    run_rows(1);
    total++; if (timed_out) begin bad++; $display("FAIL areset_row_timeout: got timeout want idle"); end
    total++; if (lat_row[0] !== 4'd0) begin bad++; $display("FAIL areset_restart_row: got %0d want 0", lat_row[0]); end
    total++; if (busy_cycles != 108) begin bad++; $display("FAIL areset_row_duration: got %0d want 108", busy_cycles); end
  endtask

  task automatic test_frame_wrap();
    apply_reset();
    cfg_clk_div = 8'd0;
    cfg_on_time = 16'd10;
    @(negedge tb_ACLK);
    run_rows(16 * 108 + 1);
    total++; if (timed_out) begin bad++; $display("FAIL frame_timeout: got timeout want idle"); end
    total++; if (busy_cycles != 17 * 108) begin bad++; $display("FAIL frame_duration: got %0d want %0d", busy_cycles, 17 * 108); end
    total++; if (lats != 17) begin bad++; $display("FAIL frame_lat_count: got %0d want 17", lats); end
    for (int i = 0; i < 17; i++) begin
      total++;
      if (lat_row[i] !== 4'(i % 16)) begin
        bad++; $display("FAIL frame_row_seq %0d: got %0d want %0d", i, lat_row[i], i % 16);
      end
    end
    total++; if (fd_cnt != 1) begin bad++; $display("FAIL frame_done_count: got %0d want 1", fd_cnt); end
    total++; if (fd_at != 16 * 108) begin bad++; $display("FAIL frame_done_cycle: got %0d want %0d", fd_at, 16 * 108); end
    total++; if (fd_oe !== 1'b1) begin bad++; $display("FAIL frame_done_oe_n: got %b want 1", fd_oe); end
  endtask

  task automatic test_disable_mid_row();
    cfg_clk_div = 8'd1;
    cfg_on_time = 16'd0;
    @(negedge tb_ACLK);
    run_rows(51);
    total++; if (drop_addr !== 9'd42) begin bad++; $display("FAIL disable_at_col10: got %0d want 42", drop_addr); end
    total++; if (timed_out) begin bad++; $display("FAIL disable_timeout: got timeout want idle"); end
    total++; if (rises != 32) begin bad++; $display("FAIL disable_clk_rises: got %0d want 32", rises); end
    total++; if (lats != 1) begin bad++; $display("FAIL disable_lat_pulses: got %0d want 1", lats); end
    total++; if (oe_low != 0) begin bad++; $display("FAIL disable_oe_never_low: got %0d want 0", oe_low); end
    total++; if (busy_cycles != 162) begin bad++; $display("FAIL disable_duration: got %0d want 162", busy_cycles); end
    total++; if (lat_row[0] !== 4'd1) begin bad++; $display("FAIL disable_row_addr: got %0d want 1", lat_row[0]); end
    @(negedge tb_ACLK);
    @(negedge tb_ACLK);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL disable_idle_busy: got %b want 0", busy); end
    total++; if (oe_n !== 1'b1) begin bad++; $display("FAIL disable_idle_oe_n: got %b want 1", oe_n); end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    cfg_enable  = 1'b0;
    cfg_clk_div = 8'd0;
    cfg_on_time = 16'd0;
    hot_addr    = 9'd5;
    tb_ARESETN  = 1'b1;
    test_reset();
    test_single_row();
    test_async_reset();
    test_frame_wrap();
    test_disable_mid_row();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ledpanel_scan_ctrl.md
LEDPANEL_SCAN_CTRL -- requirements
Module: ledpanel_scan_ctrl

Interface
REQ-001 The block SHALL have parameter COLS, default 32, meaning pixels shifted per row.
REQ-002 The block SHALL have parameter ROWS, default 16, meaning row pairs per frame; ROW_W = clog2(ROWS), COL_W = clog2(COLS).
REQ-003 The block SHALL have these ports (one clock, ACLK; reset ARESETN is asynchronous, active-low):
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- cfg_enable  in  1  scan enable, from the AXI-Lite register bank.
- cfg_clk_div  in  8  panel clock half-period minus 1, in ACLK cycles.
- cfg_on_time  in  16  oe_n low time per row, in ACLK cycles.
- rd_addr  out  ROW_W+COL_W  frame buffer read address {row, col}.
- rd_data  in  6  pixel word {r2,g2,b2,r1,g1,b1}, valid 1 cycle after rd_addr.
- rgb  out  6  panel data lines.
- panel_clk  out  1  panel shift clock.
- lat  out  1  panel latch.
- oe_n  out  1  panel output enable, active-low.
- row_addr  out  ROW_W  panel row select.
- busy  out  1  high when state is not IDLE.
- frame_done  out  1  single-cycle pulse at end of the last row.

Function
REQ-004 The FSM SHALL have states IDLE, ADDR, LOAD, CLK_HI, LATCH, DISPLAY, NEXT.
REQ-005 IDLE: oe_n=1, panel_clk=0, lat=0; when cfg_enable=1, go to ADDR with col=0 and capture cfg_clk_div and cfg_on_time.
REQ-006 Configuration SHALL be captured only on IDLE->ADDR and on NEXT->ADDR; changes mid-row take effect at the next row.
REQ-007 ADDR (1 cycle): rd_addr={row,col}; go to LOAD.
REQ-008 LOAD (div+1 cycles): rgb<=rd_data on the first cycle; panel_clk=0; go to CLK_HI.
REQ-009 CLK_HI (div+1 cycles): panel_clk=1, rgb held; if col==COLS-1 go to LATCH, else col++ and go to ADDR.
REQ-010 LATCH (1 cycle): oe_n=1, lat=1, panel_clk=0, row_addr<=row; go to DISPLAY.
REQ-011 DISPLAY: oe_n=0 for exactly on_time cycles, then go to NEXT; on_time=0 SHALL skip DISPLAY with oe_n held at 1.
REQ-012 NEXT (1 cycle): oe_n=1. If row==ROWS-1: row<=0 and frame_done=1; else row++. Then go to ADDR if cfg_enable=1, else IDLE.
REQ-013 Deasserting cfg_enable mid-row SHALL NOT abort the row; the row completes through NEXT, then the FSM enters IDLE.
REQ-014 oe_n SHALL be 1 in every state except DISPLAY, and lat SHALL be 1 only in LATCH.
REQ-015 One row SHALL take COLS*(2*(div+1)+1)+2+on_time cycles.
REQ-016 The half-period and on-time counters SHALL be down-counters loaded on state entry; the row counter SHALL wrap modulo ROWS.

Reset
REQ-017 ARESETN low SHALL immediately force the following values, regardless of ACLK: state=IDLE, oe_n=1, panel_clk=0, lat=0, rgb=0, row_addr=0, rd_addr=0, busy=0, frame_done=0, and all counters 0.
REQ-018 Reset asserted mid-DISPLAY SHALL blank the panel (oe_n=1) asynchronously.

Structure
REQ-019 The package ledpanel_pkg SHALL hold the FSM state enum, RGB_W=6, and the default COLS and ROWS.
REQ-020 A single sub-module, ledpanel_timer (a loadable 16-bit down-counter with a zero flag), SHALL serve both the half-period and on-time delays.

Verification
REQ-021 Reset check: with ARESETN=0, sample all outputs -> oe_n=1, and every other output is 0.
REQ-022 Single row timing: enable=1, div=0, on_time=10 -> 32 panel_clk rising edges, one lat pulse, oe_n low for exactly 10 cycles, row_addr=0, row duration 108 cycles.
REQ-023 Data alignment: memory model returns 6'b101010 at {row 0, col 5} and 0 elsewhere -> rgb=6'b101010 only across the 6th panel_clk rising edge.
REQ-024 Frame wrap: run 16 rows -> row_addr sequence 0..15 then 0, exactly one frame_done pulse, in NEXT after row 15.
REQ-025 Disable at col 10 -> the row completes (32 clocks, latch, display), then IDLE with busy=0; on_time=0 -> oe_n never low.
REQ-026 Async reset pulse asserted between clock edges mid-DISPLAY -> oe_n=1 before the next ACLK edge, and the FSM restarts from row 0.
